io_ports: RTL and testbench
===========================

# io_ports

Memory-mapped I/O responder for the 16-bit LEGv8 datapath. It sits on the data-memory bus beside data RAM and answers the LD/ST traffic that programs aim at the 0xfffX port window. It provides:
- synchronized, debounced switch inputs;
- a change-pending status flag;
- a writable, readable 7-segment display register.

## Interface

Parameters:
- NSW, 2: number of switch inputs (sw0 = bit 0).
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a switch change is accepted; legal range 1..65535.

Ports:
- clock, input, 1: single system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-low; sampled on the rising edge of clock.
- addr, input, 16: data-bus byte address.
- wdata, input, 16: store data.
- memwrite, input, 1: store strobe, valid for the current cycle.
- memread, input, 1: load strobe, valid for the current cycle.
- rdata, output, 16: load data, combinational.
- io_hit, output, 1: addr is in 0xfff0..0xffff; data RAM must not respond.
- sw, input, NSW: raw asynchronous switch levels.
- seg, output, 7: display pattern abcdefg, a = bit 6, 1 = lit.

## Operation

Register map (full 16-bit compare):
- 0xfff0 SWITCH, read-only: bits[NSW-1:0] = debounced switch levels; other bits 0.
- 0xfff2 STATUS, read-only: bit 0 = change pending; other bits 0. A read (memread with this address) clears the flag on that edge.
- 0xfffa DISPLAY, read/write: bits[6:0] = seg register; bits[15:7] read 0 and are ignored on write.
- Any other address in the window: reads 0, writes ignored.
- Outside the window: rdata = 0, io_hit = 0.

Switch path, per bit:
- Two-flop synchronizer sync1 → sync2.
- Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES+1); stable bit st.
- If sync2 == st: cnt ← 0.
- Else if cnt == DEBOUNCE_CYCLES-1: st ← sync2, cnt ← 0, and the change flag is set.
- Else: cnt ← cnt+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches st.

Change flag:
- Set when any bit's st toggles.
- Set and clear-on-read in the same cycle: set wins, flag stays 1.

Display:
- When memwrite=1 and addr=0xfffa: seg ← wdata[6:0].
- memwrite and memread asserted together: the write is performed, and rdata shows the old register value.

Reset (reset=0 at an edge):
- Clears sync1, sync2, cnt, st, the change flag and seg (seg = 7'b0000000).
- Reset overrides a simultaneous write, read-clear or debounce event.
- An in-progress debounce count is discarded; after reset the switch is re-evaluated from st = 0.

## Timing

- rdata and io_hit are combinational from addr and the registers. A single-cycle LD sees data in the same cycle.
- seg updates on the edge that ends the store cycle and is visible the following cycle.
- Switch latency: a raw change stable before edge E appears in SWITCH and STATUS after edge E+1+DEBOUNCE_CYCLES, i.e. 2+DEBOUNCE_CYCLES cycles including synchronization.
- A STATUS read sees the pre-clear value; the flag reads 0 from the next cycle unless it is re-set.
- No handshake or wait states; every access completes in one cycle.

## Structure

Shared package, e.g. io_pkg:
- address constants IO_BASE=16'hfff0, IO_SWITCH=16'hfff0, IO_STATUS=16'hfff2, IO_DISPLAY=16'hfffa;
- 7-segment patterns SEG_0=7'b1111110, SEG_1=7'b0110000.

Sub-module io_debounce (one switch bit):
- parameter DEBOUNCE_CYCLES;
- ports clock, reset, raw, stable, toggled (one-cycle pulse);
- instantiated NSW times in a generate loop.

Top level holds the change flag, the display register, the address decode and the read mux.

## Test plan

All scenarios use NSW=2, DEBOUNCE_CYCLES=4.
- Reset: hold reset=0 for 2 edges with sw=2'b11 → seg=0, SWITCH reads 0, STATUS reads 0; SWITCH reads 16'h0003 exactly 6 cycles after reset releases.
- Debounce accept: sw0 0→1 and held → SWITCH bit 0 = 1 after edge E+5, not at E+4; STATUS reads 1; a second STATUS read in the next cycle reads 0.
- Glitch reject: sw0 pulsed high for 3 cycles → SWITCH stays 0, STATUS stays 0. Repeat with a 4-cycle pulse → accepted.
- Display write/readback: ST 16'hff30 to 0xfffa → next cycle seg=7'b0110000; LD 0xfffa returns 16'h0030. Write SEG_0 → seg=7'b1111110.
- Set-vs-clear collision: STATUS read issued in the same cycle as a debounced toggle → flag reads 1 in the following cycle.
- Decode: store to 0xfff0 and 0xfff4 → seg unchanged. Load from 0x0010 → io_hit=0, rdata=0. Load from 0xfffe → io_hit=1, rdata=0.

Source files
------------

// File: rtl/io_ports_pkg.sv
// Shared definitions for the memory-mapped I/O port block: register addresses,
// display patterns and the address decoder used by the top level.
package io_ports_pkg;

  localparam logic [15:0] IO_BASE    = 16'hfff0;
  localparam logic [15:0] IO_SWITCH  = 16'hfff0;
  localparam logic [15:0] IO_STATUS  = 16'hfff2;
  localparam logic [15:0] IO_DISPLAY = 16'hfffa;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_SWITCH,
    REG_STATUS,
    REG_DISPLAY
  } io_reg_e;

  // Full 16-bit compare; anything else in the window decodes to REG_NONE.
  function automatic io_reg_e decode_reg(input logic [15:0] a);
    io_reg_e r;
    r = REG_NONE;
    if (a == IO_SWITCH)       r = REG_SWITCH;
    else if (a == IO_STATUS)  r = REG_STATUS;
    else if (a == IO_DISPLAY) r = REG_DISPLAY;
    return r;
  endfunction

endpackage

// File: rtl/io_ports_debounce.sv
// One switch bit: two-flop synchronizer followed by a run-length debouncer.
// toggled pulses in the cycle whose closing edge updates stable.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic toggled
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  assign toggled = (sync2 != stable) && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_ports.sv
// Memory-mapped I/O responder for the 0xfffX window: debounced switches,
// a sticky change flag cleared on read, and a 7-segment display register.
module io_ports
  import io_ports_pkg::*;
#(
  parameter int NSW             = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [15:0]     addr,
  input  logic [15:0]     wdata,
  input  logic            memwrite,
  input  logic            memread,
  output logic [15:0]     rdata,
  output logic            io_hit,
  input  logic [NSW-1:0]  sw,
  output logic [6:0]      seg
);

  logic [NSW-1:0] stable;
  logic [NSW-1:0] toggled;
  logic           flag;
  io_reg_e        sel;
  logic           unused_wdata;

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .raw     (sw[i]),
      .stable  (stable[i]),
      .toggled (toggled[i])
    );
  end

  assign sel          = decode_reg(addr);
  assign io_hit       = (addr[15:4] == IO_BASE[15:4]);
  assign unused_wdata = ^wdata[15:7];

  always_comb begin
    rdata = '0;
    case (sel)
      REG_SWITCH:  rdata[NSW-1:0] = stable;
      REG_STATUS:  rdata[0]       = flag;
      REG_DISPLAY: rdata[6:0]     = seg;
      default:     rdata          = '0;
    endcase
  end

  // A toggle landing on the same edge as a STATUS read keeps the flag set.
  always_ff @(posedge clock) begin
    if (!reset) begin
      flag <= 1'b0;
      seg  <= '0;
    end else begin
      if (|toggled) begin
        flag <= 1'b1;
      end else if (memread && (sel == REG_STATUS)) begin
        flag <= 1'b0;
      end
      if (memwrite && (sel == REG_DISPLAY)) begin
        seg <= wdata[6:0];
      end
    end
  end

endmodule

// File: tb/tb_io_ports.sv
// Self-checking bench for io_ports: directed scenarios followed by random bus
// and switch traffic, all compared against a run-length behavioural model.
module tb_io_ports;

  localparam int NSW = 2;
  localparam int DC  = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [15:0]    addr = '0;
  logic [15:0]    wdata = '0;
  logic           memwrite = 1'b0;
  logic           memread = 1'b0;
  logic [15:0]    rdata;
  logic           io_hit;
  logic [NSW-1:0] sw = '0;
  logic [6:0]     seg;

  int checks = 0;
  int passes = 0;

  // Reference model: raw history delayed two edges, and per-bit run length
  // of edges on which the delayed value disagreed with the accepted value.
  logic [NSW-1:0] m_hist[$];
  logic [NSW-1:0] m_st;
  int             m_run[NSW];
  logic           m_flag;
  logic [6:0]     m_seg;

  logic [NSW-1:0] sw_now;
  logic [15:0]    r_addr;
  int             pick;

  io_ports #(
    .NSW             (NSW),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .memwrite (memwrite),
    .memread  (memread),
    .rdata    (rdata),
    .io_hit   (io_hit),
    .sw       (sw),
    .seg      (seg)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] exp_rdata(input logic [15:0] a);
    logic [15:0] r;
    r = 16'h0000;
    if (a == 16'hfff0)      r = {{(16-NSW){1'b0}}, m_st};
    else if (a == 16'hfff2) r = {15'b0, m_flag};
    else if (a == 16'hfffa) r = {9'b0, m_seg};
    return r;
  endfunction

  function automatic logic exp_hit(input logic [15:0] a);
    return (a >= 16'hfff0);
  endfunction

  task automatic model_reset();
    m_hist = {};
    m_hist.push_back('0);
    m_hist.push_back('0);
    m_st   = '0;
    for (int b = 0; b < NSW; b++) m_run[b] = 0;
    m_flag = 1'b0;
    m_seg  = '0;
  endtask

  task automatic model_edge();
    logic [NSW-1:0] synced;
    logic           any_toggle;
    if (!reset) begin
      model_reset();
    end else begin
      any_toggle = 1'b0;
      synced = m_hist[0];
      for (int b = 0; b < NSW; b++) begin
        if (synced[b] != m_st[b]) begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            m_st[b]    = synced[b];
            m_run[b]   = 0;
            any_toggle = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      void'(m_hist.pop_front());
      m_hist.push_back(sw);
      if (any_toggle) m_flag = 1'b1;
      else if (memread && addr == 16'hfff2) m_flag = 1'b0;
      if (memwrite && addr == 16'hfffa) m_seg = wdata[6:0];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one bus cycle, optionally compare outputs before the edge, then
  // advance the model across the edge and return at the falling edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] wd, input logic we,
                               input logic re, input logic [NSW-1:0] s, input bit chk);
    addr     = a;
    wdata    = wd;
    memwrite = we;
    memread  = re;
    sw       = s;
    #1;
    if (chk) begin
      checkOutput("rdata", rdata, exp_rdata(a));
      checkOutput("io_hit", {15'b0, io_hit}, {15'b0, exp_hit(a)});
      checkOutput("seg", {9'b0, seg}, {9'b0, m_seg});
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic peek(input logic [15:0] a);
    addr     = a;
    memwrite = 1'b0;
    memread  = 1'b0;
    #1;
  endtask

  initial begin
    model_reset();

    // Reset held for two edges with switches high and a display store pending
    reset = 1'b0;
    applyStimulus(16'hfffa, 16'h007f, 1'b1, 1'b0, 2'b11, 1'b0);
    applyStimulus(16'hfff2, 16'h0000, 1'b0, 1'b1, 2'b11, 1'b1);
    peek(16'hfff0); checkOutput("reset_switch", rdata, 16'h0000);
    peek(16'hfff2); checkOutput("reset_status", rdata, 16'h0000);
    checkOutput("reset_seg", {9'b0, seg}, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b11, 1'b1);
    peek(16'hfff0); checkOutput("post_reset_5", rdata, 16'h0000);
    applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b11, 1'b1);
    peek(16'hfff0); checkOutput("post_reset_6", rdata, 16'h0003);

    // Debounce accept on sw0
    for (int i = 0; i < 8; i++) applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    applyStimulus(16'hfff2, 16'h0, 1'b0, 1'b1, 2'b00, 1'b1);
    peek(16'hfff2); checkOutput("status_cleared", rdata, 16'h0000);
    for (int i = 0; i < 5; i++) applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b01, 1'b1);
    peek(16'hfff0); checkOutput("accept_e4", rdata, 16'h0000);
    applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b01, 1'b1);
    peek(16'hfff0); checkOutput("accept_e5", rdata, 16'h0001);
    peek(16'hfff2); checkOutput("accept_status", rdata, 16'h0001);
    applyStimulus(16'hfff2, 16'h0, 1'b0, 1'b1, 2'b01, 1'b1);
    peek(16'hfff2); checkOutput("status_reread", rdata, 16'h0000);

    // Glitch reject (3 cycles) then accept (4 cycles)
    for (int i = 0; i < 8; i++) applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    applyStimulus(16'hfff2, 16'h0, 1'b0, 1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    peek(16'hfff0); checkOutput("glitch3_switch", rdata, 16'h0000);
    peek(16'hfff2); checkOutput("glitch3_status", rdata, 16'h0000);
    for (int i = 0; i < 4; i++) applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b01, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    peek(16'hfff2); checkOutput("glitch4_status", rdata, 16'h0001);

    // Display write, readback and write-with-read
    applyStimulus(16'hfffa, 16'hff30, 1'b1, 1'b0, 2'b00, 1'b1);
    checkOutput("seg_seg1", {9'b0, seg}, 16'h0030);
    peek(16'hfffa); checkOutput("display_read", rdata, 16'h0030);
    applyStimulus(16'hfffa, 16'h007f, 1'b1, 1'b1, 2'b00, 1'b1);
    peek(16'hfffa); checkOutput("display_rw", rdata, 16'h007f);
    applyStimulus(16'hfffa, 16'h007e, 1'b1, 1'b0, 2'b00, 1'b1);
    checkOutput("seg_seg0", {9'b0, seg}, 16'h007e);

    // STATUS read on the same edge as a debounced toggle of sw1
    applyStimulus(16'hfff2, 16'h0, 1'b0, 1'b1, 2'b00, 1'b1);
    peek(16'hfff2); checkOutput("collide_pre", rdata, 16'h0000);
    for (int i = 0; i < 5; i++) applyStimulus(16'hfff0, 16'h0, 1'b0, 1'b0, 2'b10, 1'b1);
    applyStimulus(16'hfff2, 16'h0, 1'b0, 1'b1, 2'b10, 1'b1);
    peek(16'hfff2); checkOutput("collide_set_wins", rdata, 16'h0001);

    // Decode boundaries
    applyStimulus(16'hfff0, 16'h0000, 1'b1, 1'b0, 2'b10, 1'b1);
    applyStimulus(16'hfff4, 16'h0000, 1'b1, 1'b0, 2'b10, 1'b1);
    checkOutput("decode_seg", {9'b0, seg}, 16'h007e);
    peek(16'h0010);
    checkOutput("decode_ram_rdata", rdata, 16'h0000);
    checkOutput("decode_ram_hit", {15'b0, io_hit}, 16'h0000);
    peek(16'hfffe);
    checkOutput("decode_fffe_rdata", rdata, 16'h0000);
    checkOutput("decode_fffe_hit", {15'b0, io_hit}, 16'h0001);

    // Random traffic with occasional resets
    sw_now = 2'b10;
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        0:       r_addr = 16'hfff0;
        1:       r_addr = 16'hfff2;
        2:       r_addr = 16'hfffa;
        3:       r_addr = 16'hfff4;
        4:       r_addr = 16'hfffe;
        5:       r_addr = 16'h0010;
        default: r_addr = 16'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) sw_now = NSW'($urandom);
      reset = ($urandom_range(0, 99) != 0);
      applyStimulus(r_addr, 16'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 1) == 0), sw_now, 1'b1);
    end
    reset = 1'b1;
    applyStimulus(16'hfff2, 16'h0, 1'b0, 1'b0, sw_now, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
